ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 SHALL have input clk_i, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have input rst_ni, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have input redirect_i, 1 bit: a taken branch/jump, flush and refetch.
REQ-005 SHALL have input redirect_pc_i, 32 bits: the redirect target, sampled when redirect_i=1.
REQ-006 SHALL have output imem_req_o, 1 bit: fetch request valid.
REQ-007 SHALL have output imem_addr_o, 32 bits: fetch byte address, word-aligned.
REQ-008 SHALL have input imem_gnt_i, 1 bit: memory accepts the request in the same cycle.
REQ-009 SHALL have input imem_rvalid_i, 1 bit: response valid; responses return in order, at least 1 cycle after grant.
REQ-010 SHALL have input imem_rdata_i, 32 bits: instruction word.
REQ-011 SHALL have outputs if_valid_o (1), if_pc_o (32) and if_inst_o (32): the instruction to decode.
REQ-012 SHALL have input if_ready_i, 1 bit: decode accepts when if_valid_o and if_ready_i are both 1.
REQ-013 SHALL have output misalign_o, 1 bit: misaligned redirect flag (see Configuration).

Function
REQ-014 SHALL hold the fetch PC fpc; imem_addr_o = fpc, and fpc advances by 4 (mod 2^32, wraps) on each imem_req_o&&imem_gnt_i.
REQ-015 SHALL assert imem_req_o only when occupancy + outstanding < 2, where occupancy is the 2-entry buffer fill and outstanding is granted-but-unreturned requests (0..2).
REQ-016 SHALL keep imem_req_o and imem_addr_o stable until granted, unless a redirect occurs.
REQ-017 SHALL push {pc,inst} into the 2-entry FIFO on each non-discarded imem_rvalid_i; the pc comes from a 2-entry in-flight PC queue filled at grant.
REQ-018 SHALL present the FIFO head on if_pc_o/if_inst_o with if_valid_o=1 whenever the FIFO is non-empty; it pops on handshake.
REQ-019 SHALL allow push and pop in the same cycle, with occupancy unchanged; the credit rule of REQ-015 makes overflow impossible.
REQ-020 SHALL handle a redirect as follows: fpc<=redirect_pc_i, FIFO flushed, if_valid_o=0 in the next cycle, kill_cnt<=outstanding minus any response returning that cycle, and imem_req_o forced 0 in the redirect cycle.
REQ-021 SHALL have two states: RUN (kill_cnt=0) and DRAIN (kill_cnt>0).
  - In DRAIN, each imem_rvalid_i is discarded and decrements kill_cnt; DRAIN goes to RUN at 0.
  - New requests are allowed in DRAIN, subject to REQ-015 with outstanding including killed requests.
REQ-022 SHALL discard a response arriving in the redirect cycle itself.
REQ-023 SHALL ignore imem_rvalid_i when outstanding=0.
REQ-024 SHALL meet this latency with gnt=1 and rvalid one cycle after grant: redirect at cycle N, new address requested at N+1, if_valid_o with that pc at N+3.
REQ-025 SHALL, when redirect and decode handshake coincide, apply the redirect and discard the popped entry's successors.

Reset
REQ-026 SHALL, while rst_ni=0, force fpc=RESET_PC, FIFO empty, outstanding=0, kill_cnt=0, state RUN, and outputs if_valid_o=0, if_pc_o=0, if_inst_o=0, imem_req_o=0, misalign_o=0.
REQ-027 SHALL leave imem_addr_o=RESET_PC during reset.
REQ-028 SHALL assert imem_req_o no earlier than the first rising edge after rst_ni deasserts.
REQ-029 SHALL, on reset mid-operation, abandon all in-flight responses; responses arriving after reset release are ignored per REQ-023.

Configuration
REQ-030 SHALL honour macro IFETCH_MISALIGN_CHECK_EN.
  - Defined: a redirect with redirect_pc_i[1:0]!=0 sets misalign_o=1 and holds imem_req_o=0 until the next aligned redirect, which clears misalign_o.
  - Not defined: redirect_pc_i[1:0] are treated as 0 and misalign_o is tied 0.

Verification
REQ-031 Reset release, gnt=1, rvalid 1 cycle later, if_ready_i=1 -> addresses 0,4,8,... and if_pc_o 0,4,8 on consecutive cycles from cycle 3.
REQ-032 if_ready_i=0 for 10 cycles -> at most 2 requests issued, FIFO holds pc 0 and 4, no further imem_req_o until a pop.
REQ-033 gnt held 0 for 5 cycles -> imem_addr_o stays 0x0 throughout, fpc not advanced.
REQ-034 Redirect to 0x100 with 2 outstanding -> both stale responses dropped, next if_pc_o=0x100 with inst from address 0x100.
REQ-035 rst_ni pulled low with 2 outstanding and FIFO full -> all outputs at reset values immediately; first pc after release is RESET_PC.
REQ-036 With IFETCH_MISALIGN_CHECK_EN defined, redirect to 0x102 -> misalign_o=1 and no requests; redirect to 0x200 -> misalign_o=0 and fetch resumes at 0x200.

Source files
------------

// File: rtl/ifetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input
// and the decode-side instruction handoff. Names match the original flat ports.
interface ifetch_unit_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_ready_i;
  logic        misalign_o;

  modport master (
    input  redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i,
    output imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o, misalign_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, if_ready_i,
    input  imem_req_o, imem_addr_o, if_valid_o, if_pc_o, if_inst_o, misalign_o
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: credit-limited requests, in-order response queue, 2-entry
// decode FIFO, redirect with stale-response kill. Option: IFETCH_MISALIGN_CHECK_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  ifetch_unit_if.master bus
);

  typedef enum logic [0:0] {RUN, DRAIN} state_e;

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_kill, w_kill_nxt;
  logic        r_started;
  logic [31:0] r_fpc;
  logic [1:0]  r_out;
  logic [31:0] r_ipc [2];
  logic        r_iq_wp, r_iq_rp;
  logic [31:0] r_fq_pc [2];
  logic [31:0] r_fq_inst [2];
  logic        r_f_wp, r_f_rp;
  logic [1:0]  r_cnt;
  logic        r_misalign;

  logic        w_valid, w_pop, w_req, w_gnt, w_ret, w_discard, w_push;
  logic [2:0]  w_credit;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;

`ifdef IFETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)             r_misalign <= 1'b0;
    else if (bus.redirect_i) r_misalign <= |bus.redirect_pc_i[1:0];
  end
`else
  assign r_misalign = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= RUN;
      r_kill  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  // Killed responses are always the oldest outstanding ones, so a count suffices.
  always_comb begin
    w_kill_nxt = r_kill;
    if (bus.redirect_i)
      w_kill_nxt = r_out - {1'b0, w_ret};
    else if (w_ret && (r_state == DRAIN))
      w_kill_nxt = r_kill - 2'd1;
    w_state_nxt = (w_kill_nxt != '0) ? DRAIN : RUN;
  end

  // Credit counts occupancy after this cycle's pop, keeping back-to-back fetch.
  always_comb begin
    w_valid   = (r_cnt != '0);
    w_pop     = w_valid && bus.if_ready_i;
    w_credit  = {1'b0, r_cnt} + {1'b0, r_out} - {2'b00, w_pop};
    w_req     = r_started && !bus.redirect_i && !r_misalign && (w_credit < 3'd2);
    w_gnt     = w_req && bus.imem_gnt_i;
    w_ret     = bus.imem_rvalid_i && (r_out != '0);
    w_discard = bus.redirect_i || (r_state == DRAIN);
    w_push    = w_ret && !w_discard;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_started <= 1'b0;
      r_fpc     <= RESET_PC;
      r_out     <= '0;
      r_iq_wp   <= 1'b0;
      r_iq_rp   <= 1'b0;
      r_f_wp    <= 1'b0;
      r_f_rp    <= 1'b0;
      r_cnt     <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_ipc[i]     <= '0;
        r_fq_pc[i]   <= '0;
        r_fq_inst[i] <= '0;
      end
    end else begin
      r_started <= 1'b1;
      if (bus.redirect_i) r_fpc <= w_redir_pc;
      else if (w_gnt)     r_fpc <= r_fpc + 32'd4;
      r_out <= r_out + {1'b0, w_gnt} - {1'b0, w_ret};
      if (w_gnt) begin
        r_ipc[r_iq_wp] <= r_fpc;
        r_iq_wp        <= ~r_iq_wp;
      end
      if (w_ret) r_iq_rp <= ~r_iq_rp;
      if (bus.redirect_i) begin
        r_cnt  <= '0;
        r_f_wp <= 1'b0;
        r_f_rp <= 1'b0;
      end else begin
        if (w_push) begin
          r_fq_pc[r_f_wp]   <= r_ipc[r_iq_rp];
          r_fq_inst[r_f_wp] <= bus.imem_rdata_i;
          r_f_wp            <= ~r_f_wp;
        end
        if (w_pop) r_f_rp <= ~r_f_rp;
        r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  assign bus.imem_req_o  = w_req;
  assign bus.imem_addr_o = r_fpc;
  assign bus.if_valid_o  = w_valid;
  assign bus.if_pc_o     = r_fq_pc[r_f_rp];
  assign bus.if_inst_o   = r_fq_inst[r_f_rp];
  assign bus.misalign_o  = r_misalign;

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: directed phases push expected {pc,inst},
// a monitor pops and compares on every decode handshake.
module tb_ifetch_unit;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   lat    = 1;
  int   grants = 0;

  always #5 clk = ~clk;

  ifetch_unit_if bus ();

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t expq[$];
  exp_t mon_e;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Memory: fixed latency `lat` cycles after grant, in order.
  logic        sr_v [4];
  logic [31:0] sr_a [4];
  initial for (int i = 0; i < 4; i++) begin sr_v[i] = 1'b0; sr_a[i] = '0; end

  always @(negedge clk) begin
    for (int i = 3; i > 0; i--) begin
      sr_v[i] = sr_v[i-1];
      sr_a[i] = sr_a[i-1];
    end
    sr_v[0] = bus.imem_req_o && bus.imem_gnt_i;
    sr_a[0] = bus.imem_addr_o;
  end

  always @(posedge clk) begin
    #1;
    bus.imem_rvalid_i = sr_v[lat-1];
    bus.imem_rdata_i  = sr_v[lat-1] ? mem_word(sr_a[lat-1]) : 32'hDEAD_BEEF;
  end

  always @(negedge clk) begin
    if (rst_n && bus.if_valid_o && bus.if_ready_i) begin
      if (expq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %08h, expected no instruction", bus.if_pc_o);
      end else begin
        mon_e = expq.pop_front();
        chk("sb_pc", bus.if_pc_o, mon_e.pc);
        chk("sb_inst", bus.if_inst_o, mon_e.inst);
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic mid();  @(negedge clk);     endtask
  task automatic run(input int n); repeat (n) begin step(); mid(); end endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc   = start + 32'(4 * i);
      e.inst = mem_word(e.pc);
      expq.push_back(e);
    end
  endtask

  task automatic rst_checks();
    chk1("rst_if_valid", bus.if_valid_o, 1'b0);
    chk ("rst_if_pc",    bus.if_pc_o,    32'h0);
    chk ("rst_if_inst",  bus.if_inst_o,  32'h0);
    chk1("rst_req",      bus.imem_req_o, 1'b0);
    chk ("rst_addr",     bus.imem_addr_o, 32'h0);
    chk1("rst_misalign", bus.misalign_o, 1'b0);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    bus.redirect_i = 1'b0;
    #1;
    rst_checks();
    repeat (3) step();
    expq.delete();
  endtask

  task automatic wait_valid(input string name, input logic [31:0] pc);
    int n = 0;
    while (!bus.if_valid_o && n < 12) begin step(); mid(); n++; end
    chk1({name, "_valid"}, bus.if_valid_o, 1'b1);
    chk(name, bus.if_pc_o, pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.imem_gnt_i    = 1'b1;
    bus.if_ready_i    = 1'b1;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;

    // Streaming from reset, then a redirect in steady state.
    do_reset();
    push_seq(32'h0, 40);
    rst_n = 1'b1;
    mid(); chk1("a_no_req_c0", bus.imem_req_o, 1'b0);
    step(); mid(); chk1("a_req_c1", bus.imem_req_o, 1'b1); chk("a_addr_c1", bus.imem_addr_o, 32'h0);
    step(); mid(); chk("a_addr_c2", bus.imem_addr_o, 32'h4); chk1("a_valid_c2", bus.if_valid_o, 1'b0);
    for (int k = 3; k < 10; k++) begin
      step(); mid();
      chk1("a_valid_stream", bus.if_valid_o, 1'b1);
      chk("a_pc_stream", bus.if_pc_o, 32'(4 * (k - 3)));
    end
    step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h2000;
    mid(); chk1("e_req_redir_cycle", bus.imem_req_o, 1'b0);
    step(); bus.redirect_i = 1'b0; expq.delete(); push_seq(32'h2000, 20);
    mid(); chk1("e_req_n1", bus.imem_req_o, 1'b1); chk("e_addr_n1", bus.imem_addr_o, 32'h2000);
    chk1("e_valid_n1", bus.if_valid_o, 1'b0);
    step(); mid(); chk1("e_valid_n2", bus.if_valid_o, 1'b0);
    step(); mid(); chk1("e_valid_n3", bus.if_valid_o, 1'b1); chk("e_pc_n3", bus.if_pc_o, 32'h2000);
    run(6);

    // Decode stalled: only two requests, FIFO holds 0 and 4.
    bus.if_ready_i = 1'b0;
    do_reset();
    push_seq(32'h0, 20);
    rst_n = 1'b1;
    grants = 0;
    repeat (12) begin
      mid();
      if (bus.imem_req_o && bus.imem_gnt_i) grants++;
      step();
    end
    chk("b_grant_count", 32'(grants), 32'd2);
    mid();
    chk1("b_valid_held", bus.if_valid_o, 1'b1);
    chk("b_head_pc", bus.if_pc_o, 32'h0);
    chk("b_head_inst", bus.if_inst_o, mem_word(32'h0));
    chk1("b_no_req_full", bus.imem_req_o, 1'b0);
    step(); bus.if_ready_i = 1'b1;
    mid(); chk1("b_req_on_pop", bus.imem_req_o, 1'b1); chk("b_addr_on_pop", bus.imem_addr_o, 32'h8);
    run(8);

    // Grant withheld: request and address stay put.
    bus.imem_gnt_i = 1'b0;
    do_reset();
    push_seq(32'h0, 20);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(); mid();
      chk1("c_req_stall", bus.imem_req_o, 1'b1);
      chk("c_addr_stall", bus.imem_addr_o, 32'h0);
    end
    step(); bus.imem_gnt_i = 1'b1;
    mid(); chk("c_addr_grant", bus.imem_addr_o, 32'h0);
    step(); mid(); chk("c_addr_adv", bus.imem_addr_o, 32'h4);
    run(6);

    // Redirect with two responses in flight (2-cycle memory).
    do_reset();
    lat = 2;
    rst_n = 1'b1;
    step(); step();
    step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100;
    mid(); chk1("d_req_redir", bus.imem_req_o, 1'b0);
    step(); bus.redirect_i = 1'b0; push_seq(32'h100, 20);
    mid(); chk1("d_req_after", bus.imem_req_o, 1'b1); chk("d_addr_after", bus.imem_addr_o, 32'h100);
    chk1("d_valid_after", bus.if_valid_o, 1'b0);
    wait_valid("d_first_pc", 32'h100);
    run(8);

    // Reset with two outstanding; late response after release is ignored.
    do_reset();
    lat = 3;
    rst_n = 1'b1;
    step(); step(); step(); step();
    chk1("f_req_no_credit", bus.imem_req_o, 1'b0);
    rst_n = 1'b0;
    #1;
    rst_checks();
    expq.delete();
    push_seq(32'h0, 20);
    step(); rst_n = 1'b1;
    mid();
    wait_valid("f_first_pc", 32'h0);
    run(6);

    // Misaligned redirect target.
    do_reset();
    lat = 1;
    push_seq(32'h0, 40);
    rst_n = 1'b1;
    run(6);
    step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h102;
    mid();
    step(); bus.redirect_i = 1'b0; expq.delete();
`ifdef IFETCH_MISALIGN_CHECK_EN
    mid(); chk1("g_misalign_set", bus.misalign_o, 1'b1); chk1("g_req_blocked", bus.imem_req_o, 1'b0);
    repeat (4) begin
      step(); mid();
      chk1("g_misalign_hold", bus.misalign_o, 1'b1);
      chk1("g_req_hold", bus.imem_req_o, 1'b0);
    end
    step(); bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h200;
    mid();
    step(); bus.redirect_i = 1'b0; push_seq(32'h200, 20);
    mid(); chk1("g_misalign_clr", bus.misalign_o, 1'b0); chk1("g_req_resume", bus.imem_req_o, 1'b1);
    chk("g_addr_resume", bus.imem_addr_o, 32'h200);
    wait_valid("g_resume_pc", 32'h200);
`else
    push_seq(32'h100, 20);
    mid(); chk1("g_misalign_tied", bus.misalign_o, 1'b0); chk1("g_req_aligned", bus.imem_req_o, 1'b1);
    chk("g_addr_aligned", bus.imem_addr_o, 32'h100);
    wait_valid("g_aligned_pc", 32'h100);
`endif
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
